// File: rtl/keys_leds_pio.sv
// Avalon-MM key/LED peripheral: debounced keys with rising-edge capture and maskable IRQ,
// LED data register with atomic set/clear. Define KEYS_LEDS_BLINK_EN for per-LED hardware blink.
module keys_leds_pio #(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned NUM_LEDS        = 26,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned BLINK_DIV_W     = 24
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [2:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_LEDS-1:0] leds_export,
    output logic                irq
);

    localparam int unsigned         CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_KEYS-1:0] SYNC_IDLE = {NUM_KEYS{KEY_ACTIVE_LOW}};

    logic [NUM_KEYS-1:0] sync1, sync2, pressed;
    logic [NUM_KEYS-1:0] key_state, key_next, rise;
    logic [NUM_KEYS-1:0] edge_cap, irq_mask, w1c;
    logic [CNT_W-1:0]    db_cnt [NUM_KEYS];
    logic [NUM_LEDS-1:0] led_data, led_view;
    logic [NUM_KEYS-1:0] wd_key;
    logic [NUM_LEDS-1:0] wd_led;
    logic [31:0]         rd_mux;
    logic                unused_wd;

    assign wd_key    = avs_writedata[NUM_KEYS-1:0];
    assign wd_led    = avs_writedata[NUM_LEDS-1:0];
    assign unused_wd = ^avs_writedata;

    // Sync flops idle at the released pin level so reset release never looks like a press.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
        end else begin
            sync1 <= keys_in;
            sync2 <= sync1;
        end
    end

    assign pressed = KEY_ACTIVE_LOW ? ~sync2 : sync2;

    always_comb begin
        key_next = key_state;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if ((pressed[i] != key_state[i]) && (db_cnt[i] == CNT_MAX)) begin
                key_next[i] = pressed[i];
            end
        end
    end

    assign rise = key_next & ~key_state;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_state <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_state <= key_next;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if ((pressed[i] == key_state[i]) || (db_cnt[i] == CNT_MAX)) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w1c = (avs_write && (avs_address == 3'd1)) ? wd_key : '0;

    // A new edge in the same cycle as its W1C clear keeps the bit set.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            edge_cap <= '0;
            irq_mask <= '0;
            led_data <= '0;
        end else begin
            edge_cap <= (edge_cap & ~w1c) | rise;
            if (avs_write) begin
                case (avs_address)
                    3'd2:    irq_mask <= wd_key;
                    3'd3:    led_data <= wd_led;
                    3'd4:    led_data <= led_data | wd_led;
                    3'd5:    led_data <= led_data & ~wd_led;
                    default: ;
                endcase
            end
        end
    end

`ifdef KEYS_LEDS_BLINK_EN
    logic [NUM_LEDS-1:0]    blink_mask;
    logic [BLINK_DIV_W-1:0] blink_period, blink_cnt;
    logic                   phase;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            blink_mask   <= '0;
            blink_period <= '0;
            blink_cnt    <= '0;
            phase        <= 1'b0;
        end else begin
            if (avs_write && (avs_address == 3'd6)) begin
                blink_mask <= wd_led;
            end
            if (avs_write && (avs_address == 3'd7)) begin
                blink_period <= avs_writedata[BLINK_DIV_W-1:0];
                blink_cnt    <= '0;
                phase        <= 1'b1;
            end else if (blink_period == '0) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (blink_cnt == blink_period) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign led_view = led_data & (~blink_mask | {NUM_LEDS{phase}});
`else
    assign led_view = led_data;
`endif

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0: rd_mux[NUM_KEYS-1:0] = key_state;
            3'd1: rd_mux[NUM_KEYS-1:0] = edge_cap;
            3'd2: rd_mux[NUM_KEYS-1:0] = irq_mask;
            3'd3: rd_mux[NUM_LEDS-1:0] = led_data;
`ifdef KEYS_LEDS_BLINK_EN
            3'd6: rd_mux[NUM_LEDS-1:0]    = blink_mask;
            3'd7: rd_mux[BLINK_DIV_W-1:0] = blink_period;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
            leds_export  <= '0;
            irq          <= 1'b0;
        end else begin
            avs_readdata <= avs_read ? rd_mux : '0;
            leds_export  <= led_view;
            irq          <= |(edge_cap & irq_mask);
        end
    end

endmodule
